// File: rtl/rcvr_frame.sv
// rcvr_frame: framed MSB-first serial receiver, WORDS x WORD_W data words plus CRC-32 trailer
// Optional feature macro RCVR_CRC_CHECK_EN: CRC-32 over the data bits and a 32-bit trailer check.
//   Without it: no CRC or trailer phase, o_crc=0, o_crc_ok=1, o_done follows the last data bit.
// Ports: i_clk sample clock, i_rst_n async active-low reset, i_fs frame sync, i_d serial bit,
//   i_crc CRC seed (latched with i_fs), o_data/o_idx/o_vld completed word and its index,
//   o_crc computed CRC, o_done/o_crc_ok frame end and check result, o_abort frame cut by i_fs.
module rcvr_frame #(
  parameter int WORD_W = 16,
  parameter int WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fs,
  input  logic              i_d,
  input  logic [31:0]       i_crc,
  output logic [WORD_W-1:0] o_data,
  output logic [7:0]        o_idx,
  output logic              o_vld,
  output logic [31:0]       o_crc,
  output logic              o_done,
  output logic              o_crc_ok,
  output logic              o_abort
);
  typedef enum logic [1:0] {IDLE, DATA, TRAIL} state_t;
  state_t state;
  logic [4:0] bit_cnt;
  logic [7:0] word_cnt;
  logic [WORD_W-2:0] shift;
  logic [WORD_W-1:0] word;
  logic word_end, last_word;
  assign word = {shift, i_d};
  assign word_end = bit_cnt == 5'(WORD_W - 1);
  assign last_word = word_cnt == 8'(WORDS - 1);
`ifdef RCVR_CRC_CHECK_EN
  logic [31:0] crc, crc_n, trailer_n;
  logic [30:0] trailer;
  assign crc_n = {crc[30:0], 1'b0} ^ ((crc[31] ^ i_d) ? 32'h04C11DB7 : 32'h0);
  assign trailer_n = {trailer, i_d};
  assign o_crc = crc;
`else
  logic unused_crc;
  assign unused_crc = ^i_crc;
  assign o_crc = '0;
  assign o_crc_ok = 1'b1;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      word_cnt <= '0;
      shift <= '0;
      o_data <= '0;
      o_idx <= '0;
      o_vld <= 1'b0;
      o_done <= 1'b0;
      o_abort <= 1'b0;
`ifdef RCVR_CRC_CHECK_EN
      crc <= '0;
      trailer <= '0;
      o_crc_ok <= 1'b0;
`endif
    end else begin
      o_vld <= 1'b0;
      o_done <= 1'b0;
      o_abort <= 1'b0;
      // frame sync wins over any word/trailer completion on the same edge
      if (i_fs) begin
        state <= DATA;
        bit_cnt <= '0;
        word_cnt <= '0;
        o_abort <= state != IDLE;
`ifdef RCVR_CRC_CHECK_EN
        crc <= i_crc;
        o_crc_ok <= 1'b0;
`endif
      end else if (state == DATA) begin
        shift <= word[WORD_W-2:0];
        bit_cnt <= word_end ? '0 : bit_cnt + 5'd1;
`ifdef RCVR_CRC_CHECK_EN
        crc <= crc_n;
`endif
        if (word_end) begin
          o_data <= word;
          o_idx <= word_cnt;
          o_vld <= 1'b1;
          word_cnt <= word_cnt + 8'd1;
          if (last_word) begin
`ifdef RCVR_CRC_CHECK_EN
            state <= TRAIL;
`else
            state <= IDLE;
            o_done <= 1'b1;
`endif
          end
        end
      end
`ifdef RCVR_CRC_CHECK_EN
      else if (state == TRAIL) begin
        trailer <= trailer_n[30:0];
        bit_cnt <= bit_cnt + 5'd1;
        if (&bit_cnt) begin
          state <= IDLE;
          o_done <= 1'b1;
          o_crc_ok <= trailer_n == crc;
        end
      end
`endif
    end
endmodule

// File: doc/rcvr_frame.md
Name: rcvr_frame

Overview:
- Parametrised successor to the single-word serial receiver.
- Deserialises a framed, MSB-first, bit-serial stream into WORDS words of WORD_W bits, followed by a 32-bit CRC trailer.
- Runs a bit-serial CRC-32 over the data bits, checks it against the trailer and reports per-word valid strobes, frame done, CRC status and abort.
- Sits between the serial line front end (frame sync plus data bit) and the word consumer / register file.

Parameters:
- WORD_W, 16, data word width in bits (2..32)
- WORDS, 4, data words per frame (1..255)

Ports:
- i_clk  in  1  sample clock; one data bit per cycle
- i_rst_n  in  1  asynchronous active-low reset
- i_fs  in  1  frame sync pulse; first data bit arrives the cycle after
- i_d  in  1  serial data bit
- i_crc  in  32  CRC seed, latched on the i_fs cycle
- o_data  out  WORD_W  last completed word
- o_idx  out  8  index of o_data within the frame (0..WORDS-1)
- o_vld  out  1  one-cycle strobe: o_data/o_idx updated
- o_crc  out  32  CRC computed over the data bits of the current/last frame
- o_done  out  1  one-cycle strobe: trailer fully received
- o_crc_ok  out  1  trailer == computed CRC; valid while o_done=1 and held until next i_fs
- o_abort  out  1  one-cycle strobe: i_fs arrived while in DATA or TRAIL

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE
  - o_data=0, o_idx=0, o_vld=0, o_crc=0, o_done=0, o_crc_ok=0, o_abort=0
  - internal counters, shift register and CRC cleared
- States: IDLE, DATA, TRAIL.
  - i_fs=1 in any state -> DATA. Clears bit and word counters, loads CRC register with i_crc, clears o_crc_ok. i_d on the i_fs cycle is ignored.
  - i_fs in DATA or TRAIL additionally pulses o_abort next cycle. The partial word is discarded; no o_vld and no o_done for the aborted frame.
- DATA:
  - Each cycle shifts i_d into the shift register, MSB first, and updates the CRC.
  - CRC update, MSB-first, poly 0x04C11DB7, no reflection, no final XOR: crc_n = {crc[30:0],1'b0} ^ ((crc[31]^i_d) ? 32'h04C11DB7 : 0).
  - On the WORD_W-th bit of a word, the next edge sets o_data = {shift[WORD_W-2:0], i_d}, o_idx = word count, o_vld=1 for one cycle.
  - On the last bit of word WORDS-1 -> TRAIL. The CRC register is frozen from here.
- TRAIL:
  - 32 bits shifted into a 32-bit trailer register, MSB first.
  - After the 32nd bit: next edge pulses o_done=1 and sets o_crc_ok = (trailer == CRC register), then -> IDLE.
- IDLE: i_d ignored; the CRC register is not updated.
- o_crc is continuously driven from the CRC register. It is stable from the TRAIL entry until the next i_fs.
- Latency:
  - o_vld is exactly 1 cycle after the edge sampling a word's last bit.
  - o_done is 1 cycle after the trailer's last bit.
- Frame length: 1 + WORDS*WORD_W + 32 cycles from i_fs to the final bit. Back-to-back frames are legal: i_fs may occur the same cycle o_done is asserted.
- Simultaneous events: i_fs has priority over completion of a word or the trailer on that same edge. The completing strobe is suppressed and o_abort fires instead.
- Reset mid-frame: immediate return to IDLE; outputs take reset values; no strobes.

Optional Feature:
RCVR_CRC_CHECK_EN
- Defined: CRC register, trailer phase and o_crc_ok comparison as above.
- Not defined:
  - no CRC logic and no TRAIL state; i_crc is unused.
  - o_crc tied 0, o_crc_ok tied 1.
  - o_done pulses 1 cycle after the last bit of word WORDS-1, and the FSM returns to IDLE.
  - Frame length becomes 1 + WORDS*WORD_W cycles.

Test Plan:
- Reset: drive i_rst_n=0 mid-stream -> all outputs 0 asynchronously; after release with no i_fs, 100 random bits -> no o_vld/o_done.
- Good frame (WORD_W=16, WORDS=2, seed 32'hFFFFFFFF):
  - Stimulus: data 0x1234, 0xABCD, trailer = model CRC.
  - Required response: o_vld with (0x1234, idx 0) at cycle 18 after i_fs and (0xABCD, idx 1) at cycle 34; o_done=1, o_crc_ok=1 at cycle 66; o_crc equals the model.
- Corrupt trailer: same frame with trailer bit 0 flipped -> o_done=1, o_crc_ok=0, o_crc unchanged from the good case.
- Abort: i_fs at bit 7 of word 1 -> o_abort pulse next cycle, no second o_vld, no o_done; the following full good frame reports o_crc_ok=1.
- Back-to-back: second i_fs on the o_done cycle -> no o_abort; the second frame decodes correctly with the seed relatched from i_crc=32'h0.
- Macro off (WORD_W=8, WORDS=3): bytes 0xA5, 0x5A, 0xFF -> three o_vld pulses, o_done at cycle 26 after i_fs, o_crc=0, o_crc_ok=1.
